// File: rtl/sbox_sched.sv
// sbox_sched: time-multiplexed S-box scheduler.
//
// A single bSbox instance is shared by two requesters. The round datapath
// asks for SubBytes/InvSubBytes on a 16-byte state. The key schedule asks for
// SubWord on a 4-byte word. Each request is latched and arbitrated
// round-robin. The operand is then streamed through the S-box one byte per
// cycle, and the assembled result is returned with a one-cycle done pulse.
//
// Optional feature (macro SBOX_SCHED_PIPE_EN):
//   defined   - a register stage sits on the S-box output. Each job takes one
//               extra RUN cycle (data 19 / key 7 cycles start-to-done).
//   undefined - the S-box feeds the working register combinationally
//               (data 18 / key 6 cycles start-to-done).
//
// Ports:
//   CLK      in   1    clock, rising edge
//   RST      in   1    asynchronous active-high reset
//   d_start  in   1    datapath request pulse (ignored while d_busy)
//   d_enc    in   1    1 = forward S-box, 0 = inverse; sampled with d_start
//   d_in     in   128  state operand, byte i = d_in[8i+7:8i]
//   d_busy   out  1    datapath job pending or running
//   d_done   out  1    one-cycle pulse, d_out updated
//   d_out    out  128  SubBytes/InvSubBytes result, held between jobs
//   k_start  in   1    key request pulse (ignored while k_busy)
//   k_in     in   32   word operand, byte i = k_in[8i+7:8i]
//   k_busy   out  1    key job pending or running
//   k_done   out  1    one-cycle pulse, k_out updated
//   k_out    out  32   SubWord result (always forward S-box)
module sbox_sched (
    input  logic         CLK,
    input  logic         RST,
    input  logic         d_start,
    input  logic         d_enc,
    input  logic [127:0] d_in,
    output logic         d_busy,
    output logic         d_done,
    output logic [127:0] d_out,
    input  logic         k_start,
    input  logic [31:0]  k_in,
    output logic         k_busy,
    output logic         k_done,
    output logic [31:0]  k_out
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] D_LAST = CW'(15);
    localparam logic [CW-1:0] K_LAST = CW'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_D = 2'd1,
        RUN_K = 2'd2
    } state_t;

    state_t state, state_nx;

    // Request capture
    logic             d_pend;
    logic             k_pend;
    logic             d_enc_q;
    logic [15:0][7:0] d_op;
    logic [3:0][7:0]  k_op;

    // Arbitration / sequencing
    logic             last_k;      // 1: key was the most recent grant
    logic [CW-1:0]    cnt;
    logic             grant_d;
    logic             grant_k;

    // Decoded RUN controls
    logic             run;
    logic             is_k;
    logic [CW-1:0]    last_idx;
    logic [7:0]       sb_in;
    logic             sb_enc;
    logic [7:0]       sb_out;

    // Capture side (either the raw S-box output or its pipeline register)
    logic [7:0]       cap_byte;
    logic [CW-1:0]    cap_idx;
    logic             cap_vld;

    logic [15:0][7:0] work;
    logic [15:0][7:0] work_nx;
    logic             fin;

    assign d_busy = d_pend;
    assign k_busy = k_pend;

    // Shared S-box
    bSbox u_sbox (
        .enc (sb_enc),
        .a   (sb_in),
        .q   (sb_out)
    );

`ifdef SBOX_SCHED_PIPE_EN
    // Byte issued at cnt = i lands here one cycle later, tagged with i.
    logic [7:0]    sb_q;
    logic [CW-1:0] cap_idx_q;
    logic          cap_vld_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sb_q      <= 8'h00;
            cap_idx_q <= '0;
            cap_vld_q <= 1'b0;
        end else begin
            sb_q      <= sb_out;
            cap_idx_q <= cnt;
            cap_vld_q <= run;
        end
    end

    assign cap_byte = sb_q;
    assign cap_idx  = cap_idx_q;
    assign cap_vld  = cap_vld_q;
`else
    assign cap_byte = sb_out;
    assign cap_idx  = cnt;
    assign cap_vld  = run;
`endif

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: round-robin grant from IDLE, leave RUN after the last capture
    always_comb begin
        state_nx = state;
        grant_d  = 1'b0;
        grant_k  = 1'b0;
        case (state)
            IDLE: begin
                if (d_pend && (!k_pend || last_k)) begin
                    state_nx = RUN_D;
                    grant_d  = 1'b1;
                end else if (k_pend) begin
                    state_nx = RUN_K;
                    grant_k  = 1'b1;
                end
            end
            RUN_D, RUN_K: begin
                if (fin) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs of the FSM: which client is running and what the S-box sees
    always_comb begin
        run      = 1'b0;
        is_k     = 1'b0;
        last_idx = D_LAST;
        sb_in    = d_op[cnt];
        sb_enc   = d_enc_q;
        case (state)
            RUN_D: begin
                run = 1'b1;
            end
            RUN_K: begin
                run      = 1'b1;
                is_k     = 1'b1;
                last_idx = K_LAST;
                sb_in    = k_op[cnt[1:0]];
                sb_enc   = 1'b1;
            end
            default: ;
        endcase
    end

    // Merge the captured byte; fin marks the final byte of the job
    always_comb begin
        work_nx = work;
        fin     = 1'b0;
        if (run && cap_vld) begin
            work_nx[cap_idx] = cap_byte;
            fin              = (cap_idx == last_idx);
        end
    end

    // Byte counter and round-robin history
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt    <= '0;
            last_k <= 1'b1;
        end else begin
            if (grant_d || grant_k) begin
                cnt    <= '0;
                last_k <= grant_k;
            end else if (run && (cnt != last_idx)) begin
                // Holds at the last index so the pipelined build can drain.
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Datapath request capture; a start while pending is dropped
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            d_pend  <= 1'b0;
            d_enc_q <= 1'b0;
            d_op    <= '0;
        end else begin
            if (d_start && !d_pend) begin
                d_pend  <= 1'b1;
                d_enc_q <= d_enc;
                d_op    <= d_in;
            end else if (fin && !is_k) begin
                d_pend  <= 1'b0;
            end
        end
    end

    // Key request capture
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            k_pend <= 1'b0;
            k_op   <= '0;
        end else begin
            if (k_start && !k_pend) begin
                k_pend <= 1'b1;
                k_op   <= k_in;
            end else if (fin && is_k) begin
                k_pend <= 1'b0;
            end
        end
    end

    // Working register and result registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            work   <= '0;
            d_out  <= '0;
            k_out  <= '0;
            d_done <= 1'b0;
            k_done <= 1'b0;
        end else begin
            work   <= work_nx;
            d_done <= fin && !is_k;
            k_done <= fin && is_k;
            if (fin && !is_k) begin
                d_out <= work_nx;
            end
            if (fin && is_k) begin
                k_out <= work_nx[3:0];
            end
        end
    end

endmodule

// bSbox: combined AES forward/inverse S-box.
// Forward: affine(inv(a)). Inverse: inv(inv_affine(a)). The GF(2^8)
// inverse is a^254, formed from repeated squaring.
//
// Ports:
//   enc  in   1   1 = forward S-box, 0 = inverse
//   a    in   8   input byte
//   q    out  8   substituted byte (combinational)
module bSbox (
    input  logic       enc,
    input  logic [7:0] a,
    output logic [7:0] q
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) begin
                p = p ^ t;
            end
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] pre;
    logic [7:0] inv;

    always_comb begin
        pre = enc ? a : aff_inv(a);
        inv = gf_inv(pre);
        q   = enc ? aff_fwd(inv) : inv;
    end

endmodule

// File: tb/tb_sbox_sched.sv
// Bench for sbox_sched: directed + randomized jobs against a table model.
module tb_sbox_sched;

`ifdef SBOX_SCHED_PIPE_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int LD = 2 + 16 + P;
    localparam int LK = 2 + 4 + P;

    logic         CLK;
    logic         RST;
    logic         d_start;
    logic         d_enc;
    logic [127:0] d_in;
    logic         d_busy;
    logic         d_done;
    logic [127:0] d_out;
    logic         k_start;
    logic [31:0]  k_in;
    logic         k_busy;
    logic         k_done;
    logic [31:0]  k_out;

    sbox_sched dut (
        .CLK     (CLK),
        .RST     (RST),
        .d_start (d_start),
        .d_enc   (d_enc),
        .d_in    (d_in),
        .d_busy  (d_busy),
        .d_done  (d_done),
        .d_out   (d_out),
        .k_start (k_start),
        .k_in    (k_in),
        .k_busy  (k_busy),
        .k_done  (k_done),
        .k_out   (k_out)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]   fwd_t [256];
    logic [7:0]   inv_t [256];
    logic [127:0] d_exp_now;
    logic [31:0]  k_exp_now;

    // ---------------- reference model ----------------
    function automatic logic [7:0] bmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        for (int bit_i = 14; bit_i >= 8; bit_i--) begin
            if (p[bit_i]) p = p ^ (16'h011b << (bit_i - 8));
        end
        return p[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] c;
        logic [7:0] b;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (bmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8]
                     ^ b[(i + 7) % 8] ^ c[i];
            end
            fwd_t[x] = s;
        end
        for (int x = 0; x < 256; x++) begin
            inv_t[fwd_t[x]] = 8'(x);
        end
    endtask

    function automatic logic [127:0] m_sub(input logic enc, input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = enc ? fwd_t[x[8*i +: 8]] : inv_t[x[8*i +: 8]];
        end
        return r;
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = fwd_t[x[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One datapath job; poke=1 fires an ignored restart while busy
    task automatic run_d(input logic enc, input logic [127:0] x, input logic poke);
        int   lat;
        int   extra;
        logic seen;
        @(negedge CLK);
        d_start = 1'b1; d_enc = enc; d_in = x;
        d_exp_now = m_sub(enc, x);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge CLK);
            lat++;
            d_start = 1'b0;
            if (poke && lat == 3) begin
                d_start = 1'b1; d_enc = ~enc; d_in = ~x;
            end
            if (d_done) seen = 1'b1;
        end
        chk("d_latency", 128'(lat), 128'(LD));
        chk("d_out", d_out, d_exp_now);
        chk("d_busy_at_done", 128'(d_busy), 128'(0));
        if (poke) begin
            extra = 0;
            repeat (30) begin
                @(negedge CLK);
                if (d_done) extra++;
            end
            chk("d_extra_done", 128'(extra), 128'(0));
            chk("d_out_hold", d_out, d_exp_now);
        end
    endtask

    task automatic run_k(input logic [31:0] x);
        int   lat;
        logic seen;
        @(negedge CLK);
        k_start = 1'b1; k_in = x;
        k_exp_now = m_word(x);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge CLK);
            lat++;
            k_start = 1'b0;
            if (k_done) seen = 1'b1;
        end
        chk("k_latency", 128'(lat), 128'(LK));
        chk("k_out", 128'(k_out), 128'(k_exp_now));
        chk("k_keeps_d_out", d_out, d_exp_now);
    endtask

    int           cyc;
    int           td;
    int           tk;
    int           td2;
    int           nd;
    logic [127:0] va;
    logic [127:0] vc;
    logic [31:0]  vb;
    logic [127:0] tmp;

    initial begin
        RST = 1'b1; d_start = 1'b0; d_enc = 1'b0; d_in = '0;
        k_start = 1'b0; k_in = '0;
        d_exp_now = '0; k_exp_now = '0;
        build_tables();

        // Reset state
        @(negedge CLK);
        chk("rst_d_out", d_out, 128'(0));
        chk("rst_k_out", 128'(k_out), 128'(0));
        chk("rst_d_done", 128'(d_done), 128'(0));
        chk("rst_k_done", 128'(k_done), 128'(0));
        chk("rst_d_busy", 128'(d_busy), 128'(0));
        chk("rst_k_busy", 128'(k_busy), 128'(0));
        @(negedge CLK);
        RST = 1'b0;

        // Forward SubBytes of zero
        run_d(1'b1, 128'(0), 1'b0);
        chk("fwd_zero_const", d_out, {16{8'h63}});

        // Inverse SubBytes
        run_d(1'b0, {16{8'h63}}, 1'b0);
        chk("inv_63_const", d_out, 128'(0));
        tmp = {{15{8'h63}}, 8'hED};
        run_d(1'b0, tmp, 1'b0);
        chk("inv_ed_byte0", 128'(d_out[7:0]), 128'(8'h53));

        // Randomized datapath jobs
        for (int i = 0; i < 8; i++) begin
            run_d(1'($urandom), rnd128(), 1'b0);
        end

        // Key SubWord
        run_k(32'h09CF4F3C);
        chk("k_const", 128'(k_out), 128'(32'h018A84EB));
        for (int i = 0; i < 6; i++) begin
            run_k($urandom);
        end

        // Simultaneous start (last grant was key, so data first), then
        // restart data in its done cycle: key is served before it.
        @(negedge CLK);
        va = rnd128(); vb = $urandom; vc = rnd128();
        d_start = 1'b1; d_enc = 1'b1; d_in = va;
        k_start = 1'b1; k_in = vb;
        cyc = 0; td = -1; tk = -1; td2 = -1;
        while (td2 < 0 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            d_start = 1'b0; k_start = 1'b0;
            if (d_done) begin
                if (td < 0) begin
                    td = cyc;
                    chk("tie_d_out", d_out, m_sub(1'b1, va));
                    d_start = 1'b1; d_enc = 1'b0; d_in = vc;
                end else begin
                    td2 = cyc;
                    chk("rr_d_out", d_out, m_sub(1'b0, vc));
                end
            end
            if (k_done) begin
                tk = cyc;
                chk("tie_k_out", 128'(k_out), 128'(m_word(vb)));
            end
        end
        chk("tie_d_time", 128'(td), 128'(LD));
        chk("tie_k_time", 128'(tk), 128'(LD + 5 + P));
        chk("rr_d_time", 128'(td2), 128'(LD + 5 + P + 17 + P));
        d_exp_now = m_sub(1'b0, vc);

        // Tie with last grant = data: key goes first
        @(negedge CLK);
        va = rnd128(); vb = $urandom;
        d_start = 1'b1; d_enc = 1'b1; d_in = va;
        k_start = 1'b1; k_in = vb;
        cyc = 0; td = -1; tk = -1;
        while ((td < 0 || tk < 0) && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            d_start = 1'b0; k_start = 1'b0;
            if (d_done) td = cyc;
            if (k_done) tk = cyc;
        end
        chk("tie2_k_time", 128'(tk), 128'(LK));
        chk("tie2_d_time", 128'(td), 128'(LK + 17 + P));
        chk("tie2_d_out", d_out, m_sub(1'b1, va));
        chk("tie2_k_out", 128'(k_out), 128'(m_word(vb)));
        d_exp_now = m_sub(1'b1, va);

        // Ignored restart while busy
        run_d(1'b1, rnd128(), 1'b1);

        // Mid-job reset
        @(negedge CLK);
        d_start = 1'b1; d_enc = 1'b1; d_in = rnd128();
        @(negedge CLK);
        d_start = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("mid_rst_d_out", d_out, 128'(0));
        chk("mid_rst_k_out", 128'(k_out), 128'(0));
        chk("mid_rst_d_busy", 128'(d_busy), 128'(0));
        chk("mid_rst_d_done", 128'(d_done), 128'(0));
        @(negedge CLK);
        RST = 1'b0;
        d_exp_now = '0;
        nd = 0;
        repeat (30) begin
            @(negedge CLK);
            if (d_done) nd++;
        end
        chk("mid_rst_no_done", 128'(nd), 128'(0));
        chk("mid_rst_d_out_hold", d_out, 128'(0));
        run_d(1'b1, rnd128(), 1'b0);
        run_k($urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sbox_sched.md
# sbox_sched

Time-multiplexed scheduler that shares one internal `bSbox` instance between two requesters: the round datapath, which needs SubBytes or InvSubBytes on a 16-byte state, and the key schedule, which needs SubWord on a 4-byte word. It latches each request, arbitrates round-robin, and streams one byte per cycle through the S-box. It assembles the result and returns it with a one-cycle done pulse. It replaces 20 parallel S-box copies with one in area-constrained AES builds.

## Interface
Parameters: none.

Clock and reset are one clock, `CLK`, and one reset, `RST`. `RST` is asynchronous and active-high.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge
- `RST`  in  1  asynchronous, active-high reset
- `d_start`  in  1  datapath request pulse
- `d_enc`  in  1  1 = forward S-box, 0 = inverse; sampled with `d_start`
- `d_in`  in  128  state operand; byte i = `d_in[8i+7:8i]`; sampled with `d_start`
- `d_busy`  out  1  datapath job pending or running
- `d_done`  out  1  one-cycle pulse: `d_out` was updated
- `d_out`  out  128  SubBytes/InvSubBytes result
- `k_start`  in  1  key-schedule request pulse
- `k_in`  in  32  word operand; byte i = `k_in[8i+7:8i]`; sampled with `k_start`
- `k_busy`  out  1  key job pending or running
- `k_done`  out  1  one-cycle pulse: `k_out` was updated
- `k_out`  out  32  SubWord result; always forward S-box

## Operation
- **Per-client request capture**
  - A start pulse with busy low sets the client's pend flag and latches its operand, plus `d_enc` for the datapath.
  - A start pulse with busy high is ignored; the operand is not re-latched.
  - busy = pend. It clears in the cycle the done pulse is high.
- **FSM states.** IDLE, RUN_D, RUN_K.
  - IDLE: if exactly one pend is set, go to that client's RUN state.
  - IDLE with both set: grant the client that is not `last_grant`. `last_grant` resets to K, so the datapath wins the first tie.
  - On grant, `cnt` is cleared to 0 and `last_grant` is updated.
- **RUN behaviour**
  - The S-box input is the operand byte `cnt`. Encrypt is `d_enc_q` in RUN_D and 1 in RUN_K.
  - The S-box result is written into byte `cnt` of a shared 128-bit working register.
  - `cnt` increments by 1, 4 bits wide. The last byte index is 15 in RUN_D and 3 in RUN_K.
- **After the last byte is captured**
  - The FSM returns to IDLE.
  - The working register (low 32 bits for K) is copied to that client's output register.
  - Done pulses for one cycle and pend clears.
- IDLE may grant the other pending client in that same done cycle, giving back-to-back jobs with no extra gap.
- Outputs change only at job completion and hold between jobs. A new start during the done cycle is accepted, because busy is already low.
- While both pends are set, grants alternate strictly. Neither client can be starved: the wait is at most one job of the other client.

## Timing
- **Reset values.** All outputs 0. FSM in IDLE, `cnt` = 0, pend flags 0, `last_grant` = K, working and operand registers 0.
- **Start-to-done latency.** With a start accepted at edge t:
  - cycle t+1: IDLE grants
  - cycles t+2 … t+1+N: one byte per cycle
  - cycle t+2+N: done high
  - Data (N=16): 18 cycles. Key (N=4): 6 cycles. No contention assumed.
- **Throughput.** One S-box evaluation per cycle while in RUN. One idle arbitration cycle per job, which overlaps the previous job's done cycle.
- **Simultaneous start of both clients.** Data finishes at t+18 and key at t+23.
- **Reset mid-job.** All state is cleared immediately. No done pulse is issued and outputs return to 0.

## Configuration
- **Macro `SBOX_SCHED_PIPE_EN`**
  - Defined: a register stage sits on the S-box output. The byte issued at `cnt` = i is captured one cycle later. Each job takes one extra RUN cycle, so latency is data 19 and key 7.
  - The FSM leaves RUN only after the final byte is captured. Arbitration and handshake rules are unchanged.
- **Undefined:** the S-box path is purely combinational into the working register, with the latencies listed under Timing.

## Test plan
- **Forward SubBytes.** After reset, `d_start` with `d_enc`=1 and `d_in`=0. Required: `d_done` exactly 18 cycles later (19 with `SBOX_SCHED_PIPE_EN`) and `d_out` = 0x6363…63.
- **Inverse SubBytes.** `d_enc`=0 and `d_in` = 0x6363…63. Required: `d_out` = 0. Also send `d_in` byte0 = 0xED with all other bytes 0x63. Required: `d_out` byte0 = 0x53.
- **Key SubWord.** `k_start` with `k_in` = 0x09CF4F3C. Required: `k_done` after 6 cycles and `k_out` = 0x018A84EB. `d_out` must stay unchanged.
- **Simultaneous starts and round-robin.** Start both clients in the same cycle. Required: `d_done` at +18 and `k_done` at +23. Immediately restart both. Required: the key job is granted first this time.
- **Ignored restart.** Pulse `d_start` with a new `d_in` while `d_busy` is high. Required: the result reflects the original operand and only one `d_done` pulse is issued.
- **Mid-job reset.** Assert `RST` 5 cycles into a data job. Required: all outputs 0, no `d_done`. A fresh request after reset completes normally.
